// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Host IDs are at least one bit wide even for trivial host counts.
package bus_arb_pkg;

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbHold = 1'b1
    } arb_state_e;

    localparam int unsigned PerfCntWidth = 32;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host IDs for outstanding bus transactions.
// A pop never frees a slot for a push in the same cycle.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int unsigned PtrWidth = $clog2(Depth) + 1;
    localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [IdxWidth-1:0] wr_idx;
    logic [IdxWidth-1:0] rd_idx;
    logic [Width-1:0]    mem_q [Depth];
    logic                push_en;
    logic                pop_en;

    if (Depth > 1) begin : g_idx
        assign wr_idx = wr_ptr_q[IdxWidth-1:0];
        assign rd_idx = rd_ptr_q[IdxWidth-1:0];
    end else begin : g_idx_single
        assign wr_idx = '0;
        assign rd_idx = '0;
    end

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = ((wr_ptr_q - rd_ptr_q) == PtrWidth'(Depth));
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem_q[rd_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid bus port between hosts.
// Define BUS_ARB_PERF_EN to build the per-host grant counters.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NrHosts-1:0]      host_req_i,
    output logic [NrHosts-1:0]      host_gnt_o,
    input  logic [AddressWidth-1:0] host_addr_i [NrHosts],
    input  logic [NrHosts-1:0]      host_we_i,
    input  logic [DataWidth/8-1:0]  host_be_i [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]      host_rvalid_o,
    output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]      host_err_o,
    output logic                    dev_req_o,
    input  logic                    dev_gnt_i,
    output logic [AddressWidth-1:0] dev_addr_o,
    output logic                    dev_we_o,
    output logic [DataWidth/8-1:0]  dev_be_o,
    output logic [DataWidth-1:0]    dev_wdata_o,
    input  logic                    dev_rvalid_i,
    input  logic [DataWidth-1:0]    dev_rdata_i,
    input  logic                    dev_err_i,
    output logic                    resp_unexp_o,
    output logic [PerfCntWidth-1:0] perf_grant_cnt_o [NrHosts]
);

    localparam int unsigned IdWidth = id_width(NrHosts);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [IdWidth-1:0] held_q;
    logic [IdWidth-1:0] held_d;
    logic [IdWidth-1:0] last_q;
    logic [IdWidth-1:0] last_d;
    logic               pick_valid;
    logic [IdWidth-1:0] pick_id;
    logic               sel_valid;
    logic [IdWidth-1:0] sel_id;
    logic               grant;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [IdWidth-1:0] fifo_head;
    logic               resp_unexp_q;

    function automatic logic [IdWidth-1:0] wrap_idx(
        input logic [IdWidth-1:0] base,
        input int unsigned        k
    );
        return IdWidth'((int'(base) + k) % NrHosts);
    endfunction

    // Scan far-to-near so the host right after last_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned k = NrHosts; k >= 1; k--) begin
            if (host_req_i[wrap_idx(last_q, k)]) begin
                pick_valid = 1'b1;
                pick_id    = wrap_idx(last_q, k);
            end
        end
    end

    // A stalled request keeps its host until granted or withdrawn.
    always_comb begin
        sel_id    = pick_id;
        sel_valid = pick_valid;
        if (state_q == ArbHold) begin
            sel_id    = held_q;
            sel_valid = host_req_i[held_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ArbIdle;
            held_q  <= '0;
            last_q  <= IdWidth'(NrHosts - 1);
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        last_d  = last_q;
        unique case (state_q)
            ArbIdle: begin
                if (dev_req_o && !dev_gnt_i) begin
                    state_d = ArbHold;
                    held_d  = sel_id;
                end
            end
            ArbHold: begin
                if (!host_req_i[held_q] || dev_gnt_i) begin
                    state_d = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
        if (grant) begin
            last_d = sel_id;
        end
    end

    always_comb begin
        dev_req_o   = sel_valid & ~fifo_full;
        grant       = dev_req_o & dev_gnt_i;
        pop         = dev_rvalid_i & ~fifo_empty;
        host_gnt_o  = '0;
        host_gnt_o[sel_id] = grant;
        host_rvalid_o = '0;
        host_rvalid_o[fifo_head] = pop;
        dev_addr_o  = host_addr_i[sel_id];
        dev_we_o    = host_we_i[sel_id];
        dev_be_o    = host_be_i[sel_id];
        dev_wdata_o = host_wdata_i[sel_id];
        host_err_o  = {NrHosts{dev_err_i}};
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = dev_rdata_i;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdWidth)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (grant),
        .pop   (pop),
        .wdata (sel_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_unexp_q <= 1'b0;
        end else begin
            resp_unexp_q <= dev_rvalid_i & fifo_empty;
        end
    end

    assign resp_unexp_o = resp_unexp_q;

`ifdef BUS_ARB_PERF_EN
    logic [PerfCntWidth-1:0] perf_q [NrHosts];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                perf_q[h] <= '0;
            end
        end else if (grant) begin
            perf_q[sel_id] <= perf_q[sel_id] + 1'b1;
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            perf_grant_cnt_o[h] = perf_q[h];
        end
    end
`else
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            perf_grant_cnt_o[h] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with two hosts and two outstanding.
// Expected grant counts depend on BUS_ARB_PERF_EN.
module tb_bus_rr_arbiter;

`ifdef BUS_ARB_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    localparam logic [31:0] Addr0 = 32'h1000_0040;
    localparam logic [31:0] Addr1 = 32'h2000_0080;
    localparam logic [31:0] Wd0   = 32'hAAAA_0000;
    localparam logic [31:0] Wd1   = 32'h5555_1111;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  host_req;
    logic [1:0]  host_gnt;
    logic [31:0] host_addr [2];
    logic [1:0]  host_we;
    logic [3:0]  host_be [2];
    logic [31:0] host_wdata [2];
    logic [1:0]  host_rvalid;
    logic [31:0] host_rdata [2];
    logic [1:0]  host_err;
    logic        dev_req;
    logic        dev_gnt;
    logic [31:0] dev_addr;
    logic        dev_we;
    logic [3:0]  dev_be;
    logic [31:0] dev_wdata;
    logic        dev_rvalid;
    logic [31:0] dev_rdata;
    logic        dev_err;
    logic        resp_unexp;
    logic [31:0] perf [2];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .NrHosts        (2),
        .DataWidth      (32),
        .AddressWidth   (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .host_req_i       (host_req),
        .host_gnt_o       (host_gnt),
        .host_addr_i      (host_addr),
        .host_we_i        (host_we),
        .host_be_i        (host_be),
        .host_wdata_i     (host_wdata),
        .host_rvalid_o    (host_rvalid),
        .host_rdata_o     (host_rdata),
        .host_err_o       (host_err),
        .dev_req_o        (dev_req),
        .dev_gnt_i        (dev_gnt),
        .dev_addr_o       (dev_addr),
        .dev_we_o         (dev_we),
        .dev_be_o         (dev_be),
        .dev_wdata_o      (dev_wdata),
        .dev_rvalid_i     (dev_rvalid),
        .dev_rdata_i      (dev_rdata),
        .dev_err_i        (dev_err),
        .resp_unexp_o     (resp_unexp),
        .perf_grant_cnt_o (perf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        host_req      = '0;
        host_addr[0]  = Addr0;
        host_addr[1]  = Addr1;
        host_we       = 2'b10;
        host_be[0]    = 4'hF;
        host_be[1]    = 4'h3;
        host_wdata[0] = Wd0;
        host_wdata[1] = Wd1;
        dev_gnt       = 1'b0;
        dev_rvalid    = 1'b0;
        dev_rdata     = '0;
        dev_err       = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #2;
        chk("rst_gnt", 32'(host_gnt), 32'h0);
        chk("rst_rvalid", 32'(host_rvalid), 32'h0);
        chk("rst_devreq", 32'(dev_req), 32'h0);
        chk("rst_unexp", 32'(resp_unexp), 32'h0);
        chk("rst_perf0", perf[0], 32'h0);

        // Alternating grants with responses one cycle behind
        tick(); host_req = 2'b11; dev_gnt = 1'b1; #2;
        chk("t1_g0", 32'(host_gnt), 32'h1);
        chk("t1_addr0", dev_addr, Addr0);
        chk("t1_we0", 32'(dev_we), 32'h0);
        chk("t1_be0", 32'(dev_be), 32'hF);
        tick(); dev_rvalid = 1'b1; dev_rdata = 32'hD000_0000; #2;
        chk("t1_g1", 32'(host_gnt), 32'h2);
        chk("t1_rv0", 32'(host_rvalid), 32'h1);
        chk("t1_rd0", host_rdata[0], 32'hD000_0000);
        chk("t1_wd1", dev_wdata, Wd1);
        tick(); dev_rdata = 32'hD000_0001; #2;
        chk("t1_g2", 32'(host_gnt), 32'h1);
        chk("t1_rv1", 32'(host_rvalid), 32'h2);
        chk("t1_rd1", host_rdata[1], 32'hD000_0001);
        tick(); dev_rdata = 32'hD000_0002; #2;
        chk("t1_g3", 32'(host_gnt), 32'h2);
        chk("t1_rv2", 32'(host_rvalid), 32'h1);
        tick(); host_req = 2'b00; dev_gnt = 1'b0;
        dev_rdata = 32'hD000_0003; dev_err = 1'b1; #2;
        chk("t1_rv3", 32'(host_rvalid), 32'h2);
        chk("t1_err", 32'(host_err), 32'h3);
        chk("t1_idle_gnt", 32'(host_gnt), 32'h0);
        tick(); dev_rvalid = 1'b0; dev_err = 1'b0; #2;
        chk("t1_perf0", perf[0], PerfEn ? 32'd2 : 32'd0);
        chk("t1_perf1", perf[1], PerfEn ? 32'd2 : 32'd0);

        // Stalled request from host 1 holds its fields
        tick(); host_req = 2'b10; #2;
        chk("t2_req", 32'(dev_req), 32'h1);
        chk("t2_addr1", dev_addr, Addr1);
        chk("t2_nogrant", 32'(host_gnt), 32'h0);
        tick(); #2;
        tick(); #2;
        chk("t2_stall3", dev_addr, Addr1);
        tick(); host_req = 2'b11; #2;
        chk("t2_hold_addr", dev_addr, Addr1);
        chk("t2_hold_be", 32'(dev_be), 32'h3);
        tick(); dev_gnt = 1'b1; #2;
        chk("t2_g1", 32'(host_gnt), 32'h2);
        tick(); #2;
        chk("t2_g0", 32'(host_gnt), 32'h1);

        // FIFO full, and a pop frees a slot only one cycle later
        tick(); #2;
        chk("t3_full_req", 32'(dev_req), 32'h0);
        chk("t3_full_gnt", 32'(host_gnt), 32'h0);
        tick(); dev_rvalid = 1'b1; dev_rdata = 32'hD000_0004; #2;
        chk("t3_nobypass", 32'(dev_req), 32'h0);
        chk("t3_rv", 32'(host_rvalid), 32'h2);
        tick(); dev_rvalid = 1'b0; #2;
        chk("t3_regrant", 32'(host_gnt), 32'h2);
        tick(); host_req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b1; #2;
        chk("t3_drain0", 32'(host_rvalid), 32'h1);
        tick(); #2;
        chk("t3_drain1", 32'(host_rvalid), 32'h2);

        // Push and pop together keep the count at one
        tick(); dev_rvalid = 1'b0; host_req = 2'b01; dev_gnt = 1'b1; #2;
        chk("t4_g0", 32'(host_gnt), 32'h1);
        tick(); host_req = 2'b10; dev_rvalid = 1'b1; #2;
        chk("t4_g1", 32'(host_gnt), 32'h2);
        chk("t4_rv0", 32'(host_rvalid), 32'h1);
        tick(); host_req = 2'b11; dev_rvalid = 1'b0; #2;
        chk("t4_cnt1", 32'(host_gnt), 32'h1);
        tick(); #2;
        chk("t4_full", 32'(dev_req), 32'h0);
        tick(); host_req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b1; #2;
        chk("t4_rv_new", 32'(host_rvalid), 32'h2);
        tick(); #2;
        chk("t4_rv_last", 32'(host_rvalid), 32'h1);

        // Response with nothing outstanding
        tick(); #2;
        chk("t5_norv", 32'(host_rvalid), 32'h0);
        tick(); dev_rvalid = 1'b0; #2;
        chk("t5_unexp_hi", 32'(resp_unexp), 32'h1);
        tick(); #2;
        chk("t5_unexp_lo", 32'(resp_unexp), 32'h0);

        // Reset with two outstanding
        tick(); host_req = 2'b11; dev_gnt = 1'b1; #2;
        chk("t6_g1", 32'(host_gnt), 32'h2);
        tick(); #2;
        chk("t6_g0", 32'(host_gnt), 32'h1);
        tick(); host_req = 2'b00; dev_gnt = 1'b0; rst = 1'b1; #2;
        tick(); rst = 1'b0; #2;
        chk("t6_rst_unexp", 32'(resp_unexp), 32'h0);
        chk("t6_perf_rst", perf[1], 32'h0);
        dev_rvalid = 1'b1; #2;
        chk("t6_norv", 32'(host_rvalid), 32'h0);
        tick(); dev_rvalid = 1'b0; #2;
        chk("t6_unexp", 32'(resp_unexp), 32'h1);
        host_req = 2'b11; dev_gnt = 1'b1; #1;
        chk("t6_first_h0", 32'(host_gnt), 32'h1);
        tick(); host_req = 2'b00; dev_gnt = 1'b0; #2;
        chk("t6_perf0", perf[0], PerfEn ? 32'd1 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
